// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and the control-word type for the pipelined RV32I control path.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_F3  = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic        regWrite;
        result_src_e resultSrc;
        logic        memWrite;
        logic        jump;
        logic        branch;
        alu_ctrl_e   aluControl;
        logic        aluSrc;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_WORD = '{
        regWrite:   1'b0,
        resultSrc:  RES_ALU,
        memWrite:   1'b0,
        jump:       1'b0,
        branch:     1'b0,
        aluControl: ALU_ADD,
        aluSrc:     1'b0
    };

    // Only R-type funct3=000 with funct7[5] set subtracts; I-type addi never does.
    function automatic alu_ctrl_e aluDecode(input alu_op_e aluOp, input logic [2:0] funct3,
                                            input logic subR);
        alu_ctrl_e res;
        case (aluOp)
            ALUOP_ADD: res = ALU_ADD;
            ALUOP_SUB: res = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  res = subR ? ALU_SUB : ALU_ADD;
                    3'b010:  res = ALU_SLT;
                    3'b110:  res = ALU_OR;
                    3'b111:  res = ALU_AND;
                    default: res = ALU_ADD;
                endcase
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational stall, flush and EX-stage forwarding decisions for the 5-stage pipeline.
module hazard_unit
    import rv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] Rs1D_i,
    input  logic [REG_ADDR_W-1:0] Rs2D_i,
    input  logic [REG_ADDR_W-1:0] Rs1E_i,
    input  logic [REG_ADDR_W-1:0] Rs2E_i,
    input  logic [REG_ADDR_W-1:0] RdE_i,
    input  logic                  RegWriteE_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic                  BranchE_i,
    input  logic                  JumpE_i,
    input  logic                  ZeroE_i,
    input  logic [REG_ADDR_W-1:0] RdM_i,
    input  logic                  RegWriteM_i,
    input  logic [REG_ADDR_W-1:0] RdW_i,
    input  logic                  RegWriteW_i,
    output logic                  PCSrcE_o,
    output logic                  StallF_o,
    output logic                  StallD_o,
    output logic                  FlushD_o,
    output logic                  FlushE_o,
    output logic [1:0]            ForwardAE_o,
    output logic [1:0]            ForwardBE_o
);

    logic matchE;
    logic matchM;
    logic loadUse;
    logic rawNoFwd;
    logic stallReq;

    function automatic fwd_e fwdSel(input logic [REG_ADDR_W-1:0] rsE);
        fwd_e sel;
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == rsE))
            sel = FWD_M;
        else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == rsE))
            sel = FWD_W;
        else
            sel = FWD_RF;
        return sel;
    endfunction

    assign matchE   = (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign matchM   = (RdM_i != '0) && ((RdM_i == Rs1D_i) || (RdM_i == Rs2D_i));
    assign loadUse  = (ResultSrcE_i == RES_MEM) && matchE;
    assign rawNoFwd = !FWD_EN && ((RegWriteE_i && matchE) || (RegWriteM_i && matchM));
    assign stallReq = loadUse || rawNoFwd;

    // A taken branch/jump squashes the stalled instruction anyway, so the flush wins.
    assign PCSrcE_o    = (BranchE_i && ZeroE_i) || JumpE_i;
    assign StallF_o    = stallReq && !PCSrcE_o;
    assign StallD_o    = stallReq && !PCSrcE_o;
    assign FlushD_o    = PCSrcE_o;
    assign FlushE_o    = PCSrcE_o || stallReq;
    assign ForwardAE_o = FWD_EN ? fwdSel(Rs1E_i) : FWD_RF;
    assign ForwardBE_o = FWD_EN ? fwdSel(Rs2E_i) : FWD_RF;

endmodule

// File: rtl/pipeline_control_unit.sv
// Decodes the instruction in D and carries its control word through the E/M/W registers.
module pipeline_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            OpD,
    input  logic [2:0]            funct3D,
    input  logic [6:0]            funct7D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  ZeroE,
    output logic [1:0]            ImmSrcD,
    output logic                  IllegalD,
    output logic [ALUCTRL_W-1:0]  ALUControlE,
    output logic                  ALUSrcE,
    output logic                  PCSrcE,
    output logic                  MemWriteM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE
);

    ctrl_word_t            ctrlD;
    imm_src_e              immSrcD;
    logic                  illegalD;
    alu_op_e               aluOpD;
    logic                  unusedFunct7;

    ctrl_word_t            ctrlE_d, ctrlE_q;
    logic [REG_ADDR_W-1:0] rs1E_d, rs1E_q;
    logic [REG_ADDR_W-1:0] rs2E_d, rs2E_q;
    logic [REG_ADDR_W-1:0] rdE_d, rdE_q;

    logic                  regWriteM_q, memWriteM_q;
    result_src_e           resultSrcM_q;
    logic [REG_ADDR_W-1:0] rdM_q;

    logic                  regWriteW_q;
    result_src_e           resultSrcW_q;
    logic [REG_ADDR_W-1:0] rdW_q;

    assign unusedFunct7 = ^{funct7D[6], funct7D[4:0]};

    always_comb begin
        ctrlD    = NOP_WORD;
        immSrcD  = IMM_I;
        illegalD = 1'b0;
        aluOpD   = ALUOP_ADD;
        case (OpD)
            OP_LW: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_MEM;
                ctrlD.aluSrc    = 1'b1;
            end
            OP_SW: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                immSrcD        = IMM_S;
            end
            OP_R: begin
                ctrlD.regWrite = 1'b1;
                aluOpD         = ALUOP_F3;
            end
            OP_I: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                aluOpD         = ALUOP_F3;
            end
            OP_BEQ: begin
                ctrlD.branch = 1'b1;
                immSrcD      = IMM_B;
                aluOpD       = ALUOP_SUB;
            end
            OP_JAL: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                ctrlD.jump      = 1'b1;
                immSrcD         = IMM_J;
            end
            default: illegalD = 1'b1;
        endcase
        ctrlD.aluControl = aluDecode(aluOpD, funct3D, (OpD == OP_R) && funct7D[5]);
    end

    // An illegal instruction enters E as a full bubble so it never triggers a hazard.
    always_comb begin
        if (FlushE || illegalD) begin
            ctrlE_d = NOP_WORD;
            rs1E_d  = '0;
            rs2E_d  = '0;
            rdE_d   = '0;
        end else begin
            ctrlE_d = ctrlD;
            rs1E_d  = Rs1D;
            rs2E_d  = Rs2D;
            rdE_d   = RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrlE_q      <= NOP_WORD;
            rs1E_q       <= '0;
            rs2E_q       <= '0;
            rdE_q        <= '0;
            regWriteM_q  <= 1'b0;
            memWriteM_q  <= 1'b0;
            resultSrcM_q <= RES_ALU;
            rdM_q        <= '0;
            regWriteW_q  <= 1'b0;
            resultSrcW_q <= RES_ALU;
            rdW_q        <= '0;
        end else begin
            ctrlE_q      <= ctrlE_d;
            rs1E_q       <= rs1E_d;
            rs2E_q       <= rs2E_d;
            rdE_q        <= rdE_d;
            regWriteM_q  <= ctrlE_q.regWrite;
            memWriteM_q  <= ctrlE_q.memWrite;
            resultSrcM_q <= ctrlE_q.resultSrc;
            rdM_q        <= rdE_q;
            regWriteW_q  <= regWriteM_q;
            resultSrcW_q <= resultSrcM_q;
            rdW_q        <= rdM_q;
        end
    end

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) uHazard (
        .Rs1D_i       (Rs1D),
        .Rs2D_i       (Rs2D),
        .Rs1E_i       (rs1E_q),
        .Rs2E_i       (rs2E_q),
        .RdE_i        (rdE_q),
        .RegWriteE_i  (ctrlE_q.regWrite),
        .ResultSrcE_i (ctrlE_q.resultSrc),
        .BranchE_i    (ctrlE_q.branch),
        .JumpE_i      (ctrlE_q.jump),
        .ZeroE_i      (ZeroE),
        .RdM_i        (rdM_q),
        .RegWriteM_i  (regWriteM_q),
        .RdW_i        (rdW_q),
        .RegWriteW_i  (regWriteW_q),
        .PCSrcE_o     (PCSrcE),
        .StallF_o     (StallF),
        .StallD_o     (StallD),
        .FlushD_o     (FlushD),
        .FlushE_o     (FlushE),
        .ForwardAE_o  (ForwardAE),
        .ForwardBE_o  (ForwardBE)
    );

    assign ImmSrcD     = immSrcD;
    assign IllegalD    = illegalD;
    assign ALUControlE = ALUCTRL_W'(ctrlE_q.aluControl);
    assign ALUSrcE     = ctrlE_q.aluSrc;
    assign MemWriteM   = memWriteM_q;
    assign RegWriteW   = regWriteW_q;
    assign ResultSrcW  = resultSrcW_q;
    assign RdW         = rdW_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Drives a forwarding and a non-forwarding instance in lockstep against a stage-slot reference model.
module tb_pipeline_control_unit;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] OpD;
    logic [2:0] funct3D;
    logic [6:0] funct7D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE;

    logic [1:0] immSrc[2], resultSrcW[2], fwdA[2], fwdB[2];
    logic [2:0] aluCtrlE[2];
    logic [4:0] rdW[2];
    logic       illegal[2], aluSrcE[2], pcSrcE[2], memWriteM[2], regWriteW[2];
    logic       stallF[2], stallD[2], flushD[2], flushE[2];

    int checks = 0;
    int errors = 0;

    // One pipeline slot: what an instruction means, independent of how the RTL stores it.
    typedef struct packed {
        bit       rw;
        bit [1:0] res;
        bit       mw;
        bit       br;
        bit       jp;
        bit [2:0] alu;
        bit       asrc;
        bit [4:0] r1, r2, rd;
    } slot_t;

    typedef struct packed {
        bit       pc, stall, fD, fE;
        bit [1:0] fa, fb;
    } hz_t;

    slot_t eS[2], mS[2], wS[2];

    always #5 clk = ~clk;

    pipeline_control_unit #(.ALUCTRL_W(3), .REG_ADDR_W(5), .FWD_EN(1'b1)) dutFwd (
        .clk(clk), .rst(rst), .OpD(OpD), .funct3D(funct3D), .funct7D(funct7D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .ImmSrcD(immSrc[0]), .IllegalD(illegal[0]), .ALUControlE(aluCtrlE[0]),
        .ALUSrcE(aluSrcE[0]), .PCSrcE(pcSrcE[0]), .MemWriteM(memWriteM[0]),
        .RegWriteW(regWriteW[0]), .ResultSrcW(resultSrcW[0]), .RdW(rdW[0]),
        .StallF(stallF[0]), .StallD(stallD[0]), .FlushD(flushD[0]), .FlushE(flushE[0]),
        .ForwardAE(fwdA[0]), .ForwardBE(fwdB[0])
    );

    pipeline_control_unit #(.ALUCTRL_W(3), .REG_ADDR_W(5), .FWD_EN(1'b0)) dutNoFwd (
        .clk(clk), .rst(rst), .OpD(OpD), .funct3D(funct3D), .funct7D(funct7D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .ImmSrcD(immSrc[1]), .IllegalD(illegal[1]), .ALUControlE(aluCtrlE[1]),
        .ALUSrcE(aluSrcE[1]), .PCSrcE(pcSrcE[1]), .MemWriteM(memWriteM[1]),
        .RegWriteW(regWriteW[1]), .ResultSrcW(resultSrcW[1]), .RdW(rdW[1]),
        .StallF(stallF[1]), .StallD(stallD[1]), .FlushD(flushD[1]), .FlushE(flushE[1]),
        .ForwardAE(fwdA[1]), .ForwardBE(fwdB[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit [2:0] aluModel(bit [2:0] f3, bit subtract);
        case (f3)
            3'b000:  return subtract ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit isLegal(bit [6:0] op);
        return op inside {LW, SW, RT, IT, BEQ, JAL};
    endfunction

    function automatic bit [1:0] immModel(bit [6:0] op);
        if (op == SW)  return 2'b01;
        if (op == BEQ) return 2'b10;
        if (op == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic slot_t decodeModel();
        slot_t s = '0;
        if (!isLegal(OpD)) return s;
        s.r1 = Rs1D; s.r2 = Rs2D; s.rd = RdD;
        case (OpD)
            LW:  begin s.rw = 1; s.res = 2'b01; s.asrc = 1; end
            SW:  begin s.mw = 1; s.asrc = 1; end
            RT:  begin s.rw = 1; s.alu = aluModel(funct3D, funct7D[5]); end
            IT:  begin s.rw = 1; s.asrc = 1; s.alu = aluModel(funct3D, 1'b0); end
            BEQ: begin s.br = 1; s.alu = 3'b001; end
            default: begin s.rw = 1; s.res = 2'b10; s.jp = 1; end
        endcase
        return s;
    endfunction

    function automatic bit writes(slot_t s, bit [4:0] r);
        return s.rw && s.rd != 0 && s.rd == r;
    endfunction

    function automatic bit [1:0] fwdModel(int k, bit [4:0] r);
        if (k == 1) return 2'b00;
        if (writes(mS[k], r)) return 2'b10;
        if (writes(wS[k], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic hz_t hazardModel(int k);
        hz_t h;
        bit readsE, readsM, want;
        readsE  = writes(eS[k], Rs1D) || writes(eS[k], Rs2D);
        readsM  = writes(mS[k], Rs1D) || writes(mS[k], Rs2D);
        want    = (eS[k].res == 2'b01 && readsE) || (k == 1 && (readsE || readsM));
        h.pc    = (eS[k].br && ZeroE) || eS[k].jp;
        h.stall = want && !h.pc;
        h.fD    = h.pc;
        h.fE    = h.pc || want;
        h.fa    = fwdModel(k, eS[k].r1);
        h.fb    = fwdModel(k, eS[k].r2);
        return h;
    endfunction

    task automatic compareModel();
        for (int k = 0; k < 2; k++) begin
            hz_t h = hazardModel(k);
            checkOutput($sformatf("ImmSrcD[%0d]", k), immSrc[k], immModel(OpD));
            checkOutput($sformatf("IllegalD[%0d]", k), illegal[k], !isLegal(OpD));
            checkOutput($sformatf("ALUControlE[%0d]", k), aluCtrlE[k], eS[k].alu);
            checkOutput($sformatf("ALUSrcE[%0d]", k), aluSrcE[k], eS[k].asrc);
            checkOutput($sformatf("PCSrcE[%0d]", k), pcSrcE[k], h.pc);
            checkOutput($sformatf("MemWriteM[%0d]", k), memWriteM[k], mS[k].mw);
            checkOutput($sformatf("RegWriteW[%0d]", k), regWriteW[k], wS[k].rw);
            checkOutput($sformatf("ResultSrcW[%0d]", k), resultSrcW[k], wS[k].res);
            checkOutput($sformatf("RdW[%0d]", k), rdW[k], wS[k].rd);
            checkOutput($sformatf("StallF[%0d]", k), stallF[k], h.stall);
            checkOutput($sformatf("StallD[%0d]", k), stallD[k], h.stall);
            checkOutput($sformatf("FlushD[%0d]", k), flushD[k], h.fD);
            checkOutput($sformatf("FlushE[%0d]", k), flushE[k], h.fE);
            checkOutput($sformatf("ForwardAE[%0d]", k), fwdA[k], h.fa);
            checkOutput($sformatf("ForwardBE[%0d]", k), fwdB[k], h.fb);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic [4:0] rd,
                                 input logic z, input logic rstN);
        OpD = op; funct3D = f3; funct7D = f7; Rs1D = r1; Rs2D = r2; RdD = rd;
        ZeroE = z; rst = rstN;
        #1;
        compareModel();
    endtask

    task automatic stepClock();
        hz_t h[2];
        @(posedge clk);
        for (int k = 0; k < 2; k++) h[k] = hazardModel(k);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                eS[k] = '0; mS[k] = '0; wS[k] = '0;
            end else begin
                wS[k] = mS[k];
                mS[k] = eS[k];
                eS[k] = h[k].fE ? '0 : decodeModel();
            end
        end
        @(negedge clk);
    endtask

    task automatic nop(input logic z);
        applyStimulus(IT, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, z, 1'b1);
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [2:0] f3s[5];
        ops = '{LW, SW, RT, IT, BEQ, JAL, 7'h7f};
        f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
        for (int k = 0; k < 2; k++) begin eS[k] = '0; mS[k] = '0; wS[k] = '0; end

        // Reset held two cycles with lw in D, then the lw walks to W.
        OpD = LW; funct3D = 3'b010; funct7D = 7'h00; Rs1D = 5'd0; Rs2D = 5'd0;
        RdD = 5'd5; ZeroE = 1'b0; rst = 1'b0;
        @(negedge clk);
        stepClock();
        applyStimulus(LW, 3'b010, 7'h00, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        checkOutput("rstRegWriteW", regWriteW[0], 1'b0);
        checkOutput("rstALUSrcE", aluSrcE[0], 1'b0);
        stepClock();
        applyStimulus(LW, 3'b010, 7'h00, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
        stepClock();
        nop(1'b0);
        checkOutput("lwALUSrcE", aluSrcE[0], 1'b1);
        stepClock();
        nop(1'b0);
        stepClock();
        nop(1'b0);
        checkOutput("lwRegWriteW", regWriteW[0], 1'b1);
        checkOutput("lwResultSrcW", resultSrcW[0], 2'b01);
        checkOutput("lwRdW", rdW[0], 5'd5);
        stepClock();

        // add x3,x1,x2 ; sub x4,x3,x1 -> forward from M.
        applyStimulus(RT, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h20, 5'd3, 5'd1, 5'd4, 1'b0, 1'b1);
        stepClock();
        nop(1'b0);
        checkOutput("subForwardAE", fwdA[0], 2'b10);
        checkOutput("subALUControlE", aluCtrlE[0], 3'b001);
        stepClock();
        repeat (3) begin nop(1'b0); stepClock(); end

        // lw x5,0(x0) ; add x6,x5,x5 -> one bubble then forward from W.
        applyStimulus(LW, 3'b010, 7'h00, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1);
        checkOutput("luStallF", stallF[0], 1'b1);
        checkOutput("luFlushE", flushE[0], 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1);
        checkOutput("luStallReleased", stallF[0], 1'b0);
        stepClock();
        nop(1'b0);
        checkOutput("luForwardAE", fwdA[0], 2'b01);
        checkOutput("luForwardBE", fwdB[0], 2'b01);
        stepClock();
        repeat (3) begin nop(1'b0); stepClock(); end

        // beq taken, beq not taken, jal.
        applyStimulus(BEQ, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        stepClock();
        nop(1'b1);
        checkOutput("beqTakenPCSrc", pcSrcE[0], 1'b1);
        checkOutput("beqTakenFlushD", flushD[0], 1'b1);
        stepClock();
        applyStimulus(BEQ, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        stepClock();
        nop(1'b0);
        checkOutput("beqNotTakenFlushD", flushD[0], 1'b0);
        stepClock();
        applyStimulus(JAL, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1);
        stepClock();
        nop(1'b0);
        checkOutput("jalPCSrc", pcSrcE[0], 1'b1);
        stepClock();
        nop(1'b0);
        stepClock();
        nop(1'b0);
        checkOutput("jalResultSrcW", resultSrcW[0], 2'b10);
        stepClock();

        // Writer of x0 followed by a reader of x0: no hazard in either instance.
        applyStimulus(RT, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1);
        checkOutput("x0NoStall", stallF[1], 1'b0);
        stepClock();
        nop(1'b0);
        checkOutput("x0ForwardAE", fwdA[0], 2'b00);
        stepClock();

        // Illegal opcode.
        applyStimulus(7'h7f, 3'b000, 7'h00, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1);
        checkOutput("illegalD", illegal[0], 1'b1);
        stepClock();
        nop(1'b0);
        checkOutput("illegalNopALUSrc", aluSrcE[0], 1'b0);
        stepClock();
        repeat (3) begin nop(1'b0); stepClock(); end

        // No-forward instance: back-to-back RAW holds D for two cycles.
        applyStimulus(RT, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1);
        checkOutput("noFwdStall1", stallD[1], 1'b1);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1);
        checkOutput("noFwdStall2", stallD[1], 1'b1);
        checkOutput("noFwdForwardAE", fwdA[1], 2'b00);
        stepClock();
        applyStimulus(RT, 3'b000, 7'h00, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1);
        checkOutput("noFwdStallDone", stallD[1], 1'b0);
        stepClock();

        // Random traffic on a small register set to provoke frequent hazards.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) == 0 ? 7'($urandom_range(0, 127))
                                                    : ops[$urandom_range(0, 6)],
                          f3s[$urandom_range(0, 4)],
                          $urandom_range(0, 1) ? 7'h20 : 7'($urandom_range(0, 127) & 7'h5f),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 49) != 0);
            stepClock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
